// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 7-segment driver with hex decode, blanking, dp and PWM brightness
module seven_seg_scanner #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 16384,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [SW-1:0]         digit_sel,
  output logic                  frame_tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam int SLICE = PRESCALE / 16;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     idx;
  logic              last;
  logic              lit;
  logic [3:0]        sub;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  // next-output decode from the current slot position and live inputs
  always_comb begin
    last = cnt == CW'(PRESCALE - 1);
    sub = 4'(cnt / CW'(SLICE));
    lit = sub <= brightness && !blank[idx];
    an_n = (lit ? DIGITS'(1) << idx : '0) ^ {DIGITS{ANODE_ACTIVE_LOW}};
    seg_n = (lit ? HEX[data[4*idx +: 4]] : 7'd0) ^ {7{SEG_ACTIVE_LOW}};
    dp_n = (lit & dp_in[idx]) ^ SEG_ACTIVE_LOW;
  end
  // slot counter and digit index, digit advances when the slot wraps
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= last ? '0 : cnt + CW'(1);
      idx <= !last ? idx : idx == SW'(DIGITS - 1) ? '0 : idx + SW'(1);
    end
  // register all pin outputs together so slot and anode change in one update
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      an <= {DIGITS{ANODE_ACTIVE_LOW}};
      seg <= {7{SEG_ACTIVE_LOW}};
      dp <= SEG_ACTIVE_LOW;
      digit_sel <= '0;
      frame_tick <= 1'b0;
    end else begin
      an <= an_n;
      seg <= seg_n;
      dp <= dp_n;
      digit_sel <= idx;
      frame_tick <= idx == '0 && cnt == '0;
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: random and directed checks of four scanner configurations against a time-based model
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] data = '0;
  logic [7:0] dp_in = '0;
  logic [7:0] blank = '0;
  logic [3:0] brightness = 4'd15;
  logic [31:0] s_data;
  logic [7:0] s_dp, s_blank;
  logic [3:0] s_br;
  int n = 0;
  bit run = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [3:0] a_an; logic [6:0] a_seg; logic a_dp; logic [1:0] a_sel; logic a_ft;
  logic [3:0] b_an; logic [6:0] b_seg; logic b_dp; logic [1:0] b_sel; logic b_ft;
  logic [7:0] c_an; logic [6:0] c_seg; logic c_dp; logic [2:0] c_sel; logic c_ft;
  logic [2:0] d_an; logic [6:0] d_seg; logic d_dp; logic [1:0] d_sel; logic d_ft;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] sel;
    logic       ft;
  } o_t;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_seg_scanner #(.DIGITS(4), .PRESCALE(16), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u_a (
    .clk(clk), .reset(reset), .data(data[15:0]), .dp_in(dp_in[3:0]), .blank(blank[3:0]),
    .brightness(brightness), .an(a_an), .seg(a_seg), .dp(a_dp), .digit_sel(a_sel), .frame_tick(a_ft));
  seven_seg_scanner #(.DIGITS(4), .PRESCALE(64), .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u_b (
    .clk(clk), .reset(reset), .data(data[15:0]), .dp_in(dp_in[3:0]), .blank(blank[3:0]),
    .brightness(brightness), .an(b_an), .seg(b_seg), .dp(b_dp), .digit_sel(b_sel), .frame_tick(b_ft));
  seven_seg_scanner #(.DIGITS(8), .PRESCALE(16), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u_c (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .blank(blank),
    .brightness(brightness), .an(c_an), .seg(c_seg), .dp(c_dp), .digit_sel(c_sel), .frame_tick(c_ft));
  seven_seg_scanner #(.DIGITS(3), .PRESCALE(48), .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) u_d (
    .clk(clk), .reset(reset), .data(data[11:0]), .dp_in(dp_in[2:0]), .blank(blank[2:0]),
    .brightness(brightness), .an(d_an), .seg(d_seg), .dp(d_dp), .digit_sel(d_sel), .frame_tick(d_ft));

  always #5 clk = ~clk;

  // inputs as the DUT saw them at the last edge
  always @(posedge clk) begin
    s_data <= data;
    s_dp <= dp_in;
    s_blank <= blank;
    s_br <= brightness;
  end

  // clock edges since reset release
  always @(posedge clk or posedge reset)
    if (reset) n <= 0;
    else n <= n + 1;

  // expected outputs purely from elapsed time: output after edge n shows position t = n-1
  function automatic o_t model(input int D, input int P, input bit aal, input bit sal);
    o_t o;
    int t, cnt, idx;
    bit lit;
    logic [7:0] mask;
    mask = 8'((1 << D) - 1);
    o = '0;
    if (n > 0) begin
      t = n - 1;
      cnt = t % P;
      idx = (t / P) % D;
      lit = cnt < (int'(s_br) + 1) * P / 16 && !s_blank[idx];
      if (lit) begin
        o.an = 8'(1 << idx);
        o.seg = HEX[s_data[4*idx +: 4]];
        o.dp = s_dp[idx];
      end
      o.sel = 3'(idx);
      o.ft = (t % (D * P)) == 0;
    end
    if (aal) o.an = ~o.an & mask;
    if (sal) begin
      o.seg = ~o.seg;
      o.dp = ~o.dp;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all four instances against the model
  always @(negedge clk)
    if (run) begin
      chk("model_a", 32'({8'(a_an), a_seg, a_dp, 3'(a_sel), a_ft}), 32'(model(4, 16, 1, 1)));
      chk("model_b", 32'({8'(b_an), b_seg, b_dp, 3'(b_sel), b_ft}), 32'(model(4, 64, 0, 0)));
      chk("model_c", 32'({c_an, c_seg, c_dp, c_sel, c_ft}), 32'(model(8, 16, 1, 1)));
      chk("model_d", 32'({8'(d_an), d_seg, d_dp, 3'(d_sel), d_ft}), 32'(model(3, 48, 0, 1)));
      chk("c_onehot", 32'($countones(~c_an) <= 1), 32'd1);
    end

  task automatic wait_a(input int v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (a_sel != 2'(v) && k < 200);
    if (a_sel != 2'(v)) begin
      checks++;
      errors++;
      $display("FAIL wait_sel: digit_sel %0d never reached %0d", a_sel, v);
    end
  endtask

  initial begin
    int lit_cnt, k;
    data = 32'h1234;
    brightness = 4'd15;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(a_an), 32'h0F);
    chk("reset_seg", 32'(a_seg), 32'h7F);
    chk("reset_dp", 32'(a_dp), 32'd1);
    chk("reset_ft", 32'(a_ft), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("c1_an", 32'(a_an), 32'b1110);
    chk("c1_seg", 32'(a_seg), 32'b0011001);
    chk("c1_ft", 32'(a_ft), 32'd1);
    repeat (16) @(negedge clk);
    chk("c17_an", 32'(a_an), 32'b1101);
    chk("c17_seg", 32'(a_seg), 32'b0110000);
    repeat (47) @(negedge clk);
    chk("c64_ft", 32'(a_ft), 32'd0);
    @(negedge clk);
    chk("c65_ft", 32'(a_ft), 32'd1);
    brightness = 4'd3;
    lit_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (b_an != 0) lit_cnt++;
    end
    chk("bright3_lit", 32'(lit_cnt), 32'd64);
    brightness = 4'd0;
    lit_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (b_an != 0) lit_cnt++;
    end
    chk("bright0_lit", 32'(lit_cnt), 32'd16);
    brightness = 4'd15;
    blank = 8'b0100;
    dp_in = 8'b0001;
    data = 32'hFFFF_FFFF;
    wait_a(2);
    chk("blank_an", 32'(a_an), 32'hF);
    wait_a(0);
    chk("dp0", 32'(a_dp), 32'd0);
    chk("seg_f", 32'(a_seg), 32'b0001110);
    wait_a(1);
    chk("dp1", 32'(a_dp), 32'd1);
    blank = '0;
    dp_in = '0;
    for (int v = 0; v < 16; v++) begin
      data = {8{4'(v)}};
      wait_a(0);
      chk("sweep_a", 32'(a_seg), 32'(7'(~HEX[v])));
      repeat (256) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_sel", 32'(a_sel), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("rst_an", 32'(a_an), 32'hF);
    chk("rst_seg", 32'(a_seg), 32'h7F);
    chk("rst_dp", 32'(a_dp), 32'd1);
    chk("rst_sel", 32'(a_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_ft", 32'(a_ft), 32'd1);
    chk("restart_an", 32'(a_an), 32'b1110);
    k = 0;
    while (!c_ft && k < 300) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!c_ft && k < 300);
    chk("c_frame", 32'(k), 32'd128);
    chk("c_wrap_sel", 32'(c_sel), 32'd0);
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) data = $urandom;
      if ($urandom_range(7) == 0) dp_in = 8'($urandom);
      if ($urandom_range(7) == 0) blank = 8'($urandom) & 8'($urandom);
      if ($urandom_range(7) == 0) brightness = 4'($urandom);
      if ($urandom_range(999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
